uart_serdes: RTL



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_serdes_if.sv | 12 +
 rtl/uart_rx.sv | 128 ++++++++++++
 rtl/uart_serdes.sv | 112 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bit engine: FSM state encodings, frame
// constants and the baud-divider arithmetic used by both directions.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAITHI
    } rx_state_e;

    // Cycles per bit; callers must keep the result at 4 or more.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int calc_half(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_serdes_if.sv
// FIFO-side handshake between the UART bus wrapper and the serial engine.
interface uart_serdes_if;
    logic [7:0] txdin;
    logic       txgo;
    logic       txrdy;
    logic [7:0] rxdout;
    logic       rxnew;
    logic       rxerr;

    modport master (output txdin, txgo, input txrdy, rxdout, rxnew, rxerr);
    modport slave  (input txdin, txgo, output txrdy, rxdout, rxnew, rxerr);
endinterface

// File: rtl/uart_rx.sv
// Receive half: pin synchroniser, mid-bit sampling FSM and byte assembly.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 19200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxdout,
    output logic                 rxnew,
    output logic                 rxerr
);

    localparam int DIV      = calc_div(CLK_HZ, BAUD);
    localparam int HALF_DIV = calc_half(DIV);
    localparam int CNT_W    = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF_DIV);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic                 rxd_p0_q, rxd_p1_q, rxs;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rxdout_q, rxdout_d;
    logic                 rxnew_q, rxnew_d;
    logic                 rxerr_q, rxerr_d;

    assign rxs = rxd_p1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_p0_q <= IDLE_LVL;
            rxd_p1_q <= IDLE_LVL;
            state_q  <= RX_IDLE;
            rxdout_q <= '0;
            rxnew_q  <= 1'b0;
            rxerr_q  <= 1'b0;
        end else begin
            rxd_p0_q <= rxd;
            rxd_p1_q <= rxd_p0_q;
            state_q  <= state_d;
            rxdout_q <= rxdout_d;
            rxnew_q  <= rxnew_d;
            rxerr_q  <= rxerr_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        bitcnt_q <= bitcnt_d;
        shift_q  <= shift_d;
    end

    // Counter runs down to 1; the start check lands half a bit after the edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        rxdout_d = rxdout_q;
        rxnew_d  = 1'b0;
        rxerr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rxs != IDLE_LVL) begin
                    state_d = RX_START;
                    cnt_d   = HALF_C;
                end
            end
            RX_START: begin
                if (cnt_q == ONE_C) begin
                    if (rxs == IDLE_LVL) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d  = RX_DATA;
                        cnt_d    = DIV_C;
                        bitcnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            RX_DATA: begin
                if (cnt_q == ONE_C) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = DIV_C;
                    if (bitcnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            RX_STOP: begin
                if (cnt_q == ONE_C) begin
                    if (rxs == STOP_LVL) begin
                        rxdout_d = shift_q;
                        rxnew_d  = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        rxerr_d = 1'b1;
                        state_d = RX_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            RX_WAITHI: begin
                // Hold off until the line is released so a break reports once.
                if (rxs == IDLE_LVL) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rxdout = rxdout_q;
    assign rxnew  = rxnew_q;
    assign rxerr  = rxerr_q;

endmodule

// File: rtl/uart_serdes.sv
// 8N1 serial engine between the UART FIFOs and the pins: transmit FSM here,
// receive path in uart_rx.
module uart_serdes
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 19200
) (
    input  logic          clk,
    input  logic          rst,
    uart_serdes_if.slave  bus,
    output logic          txd,
    input  logic          rxd
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            txd_q   <= IDLE_LVL;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        bitcnt_q <= bitcnt_d;
        shift_q  <= shift_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        case (state_q)
            TX_IDLE: begin
                if (bus.txgo) begin
                    state_d = TX_START;
                    cnt_d   = DIV_C;
                    shift_d = bus.txdin;
                end
            end
            TX_START: begin
                if (cnt_q == ONE_C) begin
                    state_d  = TX_DATA;
                    cnt_d    = DIV_C;
                    bitcnt_d = '0;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            TX_DATA: begin
                if (cnt_q == ONE_C) begin
                    cnt_d = DIV_C;
                    if (bitcnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            TX_STOP: begin
                if (cnt_q == ONE_C) begin
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Pin level follows the state being entered so txd stays registered.
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            TX_STOP:  txd_d = STOP_LVL;
            default:  txd_d = IDLE_LVL;
        endcase
    end

    assign txd       = txd_q;
    assign bus.txrdy = (state_q == TX_IDLE);

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .rxdout (bus.rxdout),
        .rxnew  (bus.rxnew),
        .rxerr  (bus.rxerr)
    );

endmodule
